// File: rtl/dma_engine.sv
// dma_engine: multi-channel memory-to-memory DMA on a shared single SRAM port.
//
// Each channel holds a source address, a destination address, a word count and
// a busy flag. A single FSM moves one word per grant cycle pair. It runs
// IDLE -> ARB -> READ -> CAPT -> WRITE and returns to ARB after every word, so
// busy channels interleave word by word in round-robin order.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   cfg_we_i/ch/sel/data  config write: sel 0=SRC 1=DST 2=LEN 3=CTRL
//                         (CTRL bit0 start, bit1 abort, bit2 irq clear)
//   mem_req_o/gnt_i       SRAM port request; the grant is owned by CTL
//   mem_addr_o/we_o/di_o  SRAM address, write enable and write data
//   mem_do_i              SRAM read data, valid the cycle after a granted read
//   busy_o                per-channel transfer pending or in progress
//   done_o                per-channel one-cycle completion pulse
//   irq_o                 OR of sticky per-channel pending bits
//
// Build option: define DMA_IRQ_EN to enable completion interrupts. Without it,
// irq_o is tied low and CTRL bit2 is ignored.
module dma_engine #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 32,
    parameter int unsigned LW     = 16,
    localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned CFGW  = (AW > LW) ? AW : LW
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cfg_we_i,
    input  logic [CHW-1:0]    cfg_ch_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [CFGW-1:0]   cfg_data_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [AW-1:0]     mem_addr_o,
    output logic              mem_we_o,
    output logic [DW-1:0]     mem_di_o,
    input  logic [DW-1:0]     mem_do_i,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] done_o,
    output logic              irq_o
);

    typedef enum logic [2:0] {StIdle, StArb, StRead, StCapt, StWrite} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     src_q [NUM_CH];
    logic [AW-1:0]     src_d [NUM_CH];
    logic [AW-1:0]     dst_q [NUM_CH];
    logic [AW-1:0]     dst_d [NUM_CH];
    logic [LW-1:0]     len_q [NUM_CH];
    logic [LW-1:0]     len_d [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [CHW-1:0]    ch_q, ch_d;    // channel owning the word in flight
    logic [CHW-1:0]    rr_q, rr_d;    // first channel to consider at next ARB
    logic [DW-1:0]     buf_q, buf_d;
    logic              abort_q, abort_d;  // in-flight word belongs to an aborted channel

    logic              found;
    logic [CHW-1:0]    pick;
    logic [CHW-1:0]    cand;
    logic              in_flight;
    logic              cfg_valid;
    logic              cfg_hits_act;
    logic              locked;
    logic              wr_gnt;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        busy_d       = busy_q;
        done_d       = '0;
        ch_d         = ch_q;
        rr_d         = rr_q;
        buf_d        = buf_q;
        abort_d      = abort_q;
        found        = 1'b0;
        pick         = '0;
        cand         = '0;
        in_flight    = state_q inside {StRead, StCapt, StWrite};
        wr_gnt       = (state_q == StWrite) && mem_gnt_i;
        cfg_valid    = cfg_we_i && (int'(cfg_ch_i) < int'(NUM_CH));
        cfg_hits_act = in_flight && (cfg_ch_i == ch_q);
        locked       = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (|busy_q) state_d = StArb;
            end
            StArb: begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    cand = CHW'((int'(rr_q) + i) % int'(NUM_CH));
                    if (!found && busy_q[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                if (found) begin
                    ch_d    = pick;
                    rr_d    = (pick == CHW'(NUM_CH - 1)) ? '0 : pick + 1'b1;
                    abort_d = 1'b0;
                    state_d = StRead;
                end else begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (mem_gnt_i) state_d = StCapt;
            end
            StCapt: begin
                buf_d   = mem_do_i;
                state_d = StWrite;
            end
            StWrite: begin
                if (mem_gnt_i) begin
                    state_d = StArb;
                    // An aborted channel keeps its registers; the word is simply dropped
                    // from accounting once it has landed.
                    if (!abort_q) begin
                        src_d[ch_q] = src_q[ch_q] + 1'b1;
                        dst_d[ch_q] = dst_q[ch_q] + 1'b1;
                        len_d[ch_q] = len_q[ch_q] - 1'b1;
                        if (len_q[ch_q] == LW'(1)) begin
                            busy_d[ch_q] = 1'b0;
                            done_d[ch_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A write landing this cycle owns the channel; a config write to it is dropped.
        if (cfg_valid && !(wr_gnt && cfg_ch_i == ch_q)) begin
            // The in-flight channel stays locked after abort until its word lands.
            locked = busy_q[cfg_ch_i] || cfg_hits_act;
            unique case (cfg_sel_i)
                2'd0: if (!locked) src_d[cfg_ch_i] = cfg_data_i[AW-1:0];
                2'd1: if (!locked) dst_d[cfg_ch_i] = cfg_data_i[AW-1:0];
                2'd2: if (!locked) len_d[cfg_ch_i] = cfg_data_i[LW-1:0];
                2'd3: begin
                    if (cfg_data_i[1]) begin
                        if (busy_q[cfg_ch_i]) begin
                            busy_d[cfg_ch_i] = 1'b0;
                            if (cfg_hits_act) abort_d = 1'b1;
                        end
                    end else if (cfg_data_i[0] && !locked) begin
                        if (len_q[cfg_ch_i] == '0) begin
                            done_d[cfg_ch_i] = 1'b1;
                        end else begin
                            busy_d[cfg_ch_i] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            busy_q  <= '0;
            done_q  <= '0;
            ch_q    <= '0;
            rr_q    <= '0;
            buf_q   <= '0;
            abort_q <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            buf_q   <= buf_d;
            abort_q <= abort_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
        end
    end

    // Port drive comes from registered state only.
    always_comb begin
        mem_req_o  = (state_q == StRead) || (state_q == StWrite);
        mem_we_o   = (state_q == StWrite);
        mem_addr_o = '0;
        mem_di_o   = '0;
        if (state_q == StRead) mem_addr_o = src_q[ch_q];
        if (state_q == StWrite) begin
            mem_addr_o = dst_q[ch_q];
            mem_di_o   = buf_q;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

`ifdef DMA_IRQ_EN
    logic [NUM_CH-1:0] irq_pend_q, irq_pend_d;

    always_comb begin
        irq_pend_d = irq_pend_q;
        if (cfg_valid && cfg_sel_i == 2'd3 && cfg_data_i[2]) irq_pend_d[cfg_ch_i] = 1'b0;
        // Set after clear so a same-cycle completion is not lost.
        irq_pend_d = irq_pend_d | done_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) irq_pend_q <= '0;
        else         irq_pend_q <= irq_pend_d;
    end

    assign irq_o = |irq_pend_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine with a behavioural SRAM.
// Inputs are driven #1 after the rising edge and outputs are sampled at the same point.
module tb_dma_engine;

    localparam logic [1:0] SelSrc  = 2'd0;
    localparam logic [1:0] SelDst  = 2'd1;
    localparam logic [1:0] SelLen  = 2'd2;
    localparam logic [1:0] SelCtrl = 2'd3;
    localparam logic [31:0] Fill   = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_data = '0;
    logic        mem_req;
    logic        mem_gnt = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_di;
    logic [31:0] mem_do = '0;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic        irq;

    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] sram [65536];
    logic [16:0] acc_log [$];

    int checks = 0;
    int failures = 0;

    dma_engine u_dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_sel_i  (cfg_sel),
        .cfg_data_i (cfg_data),
        .mem_req_o  (mem_req),
        .mem_gnt_i  (mem_gnt),
        .mem_addr_o (mem_addr),
        .mem_we_o   (mem_we),
        .mem_di_o   (mem_di),
        .mem_do_i   (mem_do),
        .busy_o     (busy),
        .done_o     (done),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) sram[pre_addr] <= pre_data;
        if (mem_req && mem_gnt) begin
            if (mem_we) sram[mem_addr] <= mem_di;
            else        mem_do <= sram[mem_addr];
            acc_log.push_back({mem_we, mem_addr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_sel = sel;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic setup(input logic [1:0] ch, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n);
        cfg(ch, SelSrc, s);
        cfg(ch, SelDst, d);
        cfg(ch, SelLen, n);
    endtask

    // Ticks until done[ch] is seen; returns the tick count, or the budget on expiry.
    task automatic wait_done(input int ch, input int budget, output int n);
        n = 0;
        while (!done[ch] && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int base;
        int cnt_done;
        int cnt_req;
        logic [16:0] exp_seq [8];

        reset = 1'b1;
        for (int i = 0; i < 3; i++) preload(16'h0010 + 16'(i), 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 3; i++) preload(16'h0100 + 16'(i), Fill);
        for (int i = 0; i < 2; i++) preload(16'h0020 + 16'(i), 32'hB000_0020 + 32'(i));
        for (int i = 0; i < 2; i++) preload(16'h0040 + 16'(i), 32'hC000_0040 + 32'(i));
        preload(16'h0030, 32'h1234_5678);
        preload(16'hFFFF, 32'hFFFF_0001);
        preload(16'h0000, 32'h0000_0002);
        for (int i = 0; i < 8; i++) preload(16'h0050 + 16'(i), 32'h5500_0000 + 32'(i));
        for (int i = 0; i < 8; i++) preload(16'h0150 + 16'(i), Fill);

        // Reset state
        do_reset();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_di", mem_di, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // Single channel, three words, port always granted
        setup(2'd0, 16'h0010, 16'h0100, 16'd3);
        cfg(2'd0, SelCtrl, 16'h0001);
        check("t1_busy_next", 32'(busy), 32'h1);
        check("t1_no_req_idle", 32'(mem_req), 32'd0);
        tick();
        check("t1_no_req_arb", 32'(mem_req), 32'd0);
        tick();
        check("t1_first_read_req", 32'(mem_req), 32'd1);
        check("t1_first_read_addr", 32'(mem_addr), 32'h0010);
        check("t1_first_read_we", 32'(mem_we), 32'd0);
        // Done in the 12th cycle counting the first read request cycle as cycle 1
        wait_done(0, 40, n);
        check("t1_done_latency", 32'(n), 32'd11);
        check("t1_busy_clear", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse_1cyc", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++)
            check("t1_dst_data", sram[16'h0100 + 16'(i)], 32'hA000_0000 + 32'(i));
`ifdef DMA_IRQ_EN
        check("t1_irq_set", 32'(irq), 32'd1);
`else
        check("t1_irq_off", 32'(irq), 32'd0);
`endif

        // Two channels interleave word by word
        do_reset();
        setup(2'd0, 16'h0020, 16'h0120, 16'd2);
        setup(2'd2, 16'h0040, 16'h0140, 16'd2);
        base = acc_log.size();
        cfg(2'd0, SelCtrl, 16'h0001);
        cfg(2'd2, SelCtrl, 16'h0001);
        n = 0;
        while (busy != 4'd0 && n < 60) begin
            tick();
            n++;
        end
        check("t2_finished", 32'(busy), 32'd0);
        exp_seq[0] = {1'b0, 16'h0020};
        exp_seq[1] = {1'b1, 16'h0120};
        exp_seq[2] = {1'b0, 16'h0040};
        exp_seq[3] = {1'b1, 16'h0140};
        exp_seq[4] = {1'b0, 16'h0021};
        exp_seq[5] = {1'b1, 16'h0121};
        exp_seq[6] = {1'b0, 16'h0041};
        exp_seq[7] = {1'b1, 16'h0141};
        check("t2_access_count", 32'(acc_log.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < acc_log.size()) check("t2_port_seq", 32'(acc_log[base + i]),
                                                  32'(exp_seq[i]));
            else check("t2_port_seq_missing", 32'(0), 32'(exp_seq[i]));
        end
        check("t2_ch2_word1", sram[16'h0141], 32'hC000_0041);

        // Grant withheld for 5 cycles during READ
        do_reset();
        setup(2'd0, 16'h0030, 16'h0130, 16'd1);
        mem_gnt = 1'b0;
        cfg(2'd0, SelCtrl, 16'h0001);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_read_held_req", 32'(mem_req), 32'd1);
            check("t3_read_held_addr", 32'(mem_addr), 32'h0030);
            tick();
        end
        mem_gnt = 1'b1;
        wait_done(0, 20, n);
        // Uncontended single word completes 3 ticks after the first read: 3 + 5
        check("t3_delayed_done", 32'(5 + n), 32'd8);
        check("t3_data", sram[16'h0130], 32'h1234_5678);

        // Source address wraps at the top of the address space
        do_reset();
        setup(2'd1, 16'hFFFF, 16'h0200, 16'd2);
        base = acc_log.size();
        cfg(2'd1, SelCtrl, 16'h0001);
        wait_done(1, 40, n);
        check("t4_done_seen", 32'(done[1]), 32'd1);
        exp_seq[0] = {1'b0, 16'hFFFF};
        exp_seq[1] = {1'b1, 16'h0200};
        exp_seq[2] = {1'b0, 16'h0000};
        exp_seq[3] = {1'b1, 16'h0201};
        check("t4_access_count", 32'(acc_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < acc_log.size()) check("t4_port_seq", 32'(acc_log[base + i]),
                                                  32'(exp_seq[i]));
            else check("t4_port_seq_missing", 32'(0), 32'(exp_seq[i]));
        end
        check("t4_data0", sram[16'h0200], 32'hFFFF_0001);
        check("t4_data1", sram[16'h0201], 32'h0000_0002);

        // Abort mid-transfer, then zero-length start
        do_reset();
        setup(2'd1, 16'h0050, 16'h0150, 16'd8);
        cfg(2'd1, SelCtrl, 16'h0001);
        tick();
        tick();
        // Busy channel: this SRC write must be dropped
        cfg(2'd1, SelSrc, 16'h0070);
        for (int i = 0; i < 11; i++) tick();
        check("t5_word3_read_addr", 32'(mem_addr), 32'h0053);
        tick();
        check("t5_capt_no_req", 32'(mem_req), 32'd0);
        cfg(2'd1, SelCtrl, 16'h0002);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_inflight_write", 32'({mem_req, mem_we, mem_addr}), 32'({2'b11, 16'h0153}));
        cnt_done = 0;
        cnt_req = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done != 4'd0) cnt_done++;
            if (mem_req) cnt_req++;
        end
        check("t5_no_done", 32'(cnt_done), 32'd0);
        check("t5_no_more_req", 32'(cnt_req), 32'd0);
        check("t5_word3_written", sram[16'h0153], 32'h5500_0003);
        check("t5_word4_untouched", sram[16'h0154], Fill);
        check("t5_word7_untouched", sram[16'h0157], Fill);
        cfg(2'd1, SelLen, 16'd0);
        cfg(2'd1, SelCtrl, 16'h0001);
        check("t5_len0_done", 32'(done), 32'h2);
        check("t5_len0_busy", 32'(busy), 32'd0);
        check("t5_len0_no_req", 32'(mem_req), 32'd0);
`ifdef DMA_IRQ_EN
        check("t5_irq_set", 32'(irq), 32'd1);
`else
        check("t5_irq_off", 32'(irq), 32'd0);
`endif
        tick();
        check("t5_len0_pulse_end", 32'(done), 32'd0);
        check("t5_len0_still_no_req", 32'(mem_req), 32'd0);
        cfg(2'd1, SelCtrl, 16'h0004);
        check("t5_irq_cleared", 32'(irq), 32'd0);

        // Start and abort together on an idle channel: abort wins
        cfg(2'd3, SelLen, 16'd5);
        cfg(2'd3, SelCtrl, 16'h0003);
        check("t6_start_abort_busy", 32'(busy), 32'd0);
        check("t6_start_abort_done", 32'(done), 32'd0);
        tick();
        tick();
        check("t6_start_abort_no_req", 32'(mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
